note_lane_engine: RTL and testbench

NOTE_LANE_ENGINE -- requirements
Module: note_lane_engine

---
 rtl/note_lane_engine_pkg.sv | 24 ++
 rtl/note_lane_engine_if.sv | 13 +
 rtl/note_lane_engine_lane.sv | 116 +++++++++++
 rtl/note_lane_engine.sv | 107 ++++++++++
 tb/tb_note_lane_engine.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/note_lane_engine_pkg.sv
// Shared types and constants for the note lane engine: slot record, lane colours, helpers.
package note_pkg;

   localparam int YW = 10;  // ytop width
   localparam int CW = 12;  // coordinate compare width, wide enough that no sum wraps

   typedef struct packed {
      logic          valid;
      logic [YW-1:0] ytop;
   } slot_t;

   localparam logic [11:0] LANE_COLOR [4] = '{12'h0F0, 12'hF00, 12'hFF0, 12'h00F};

   function automatic logic [11:0] lane_color(input logic [1:0] lane);
      return LANE_COLOR[lane];
   endfunction

   function automatic logic [15:0] sat_add(input logic [15:0] a, input int unsigned b);
      logic [16:0] s;
      s = {1'b0, a} + 17'(b);
      return s[16] ? 16'hFFFF : s[15:0];
   endfunction

endpackage

// File: rtl/note_lane_engine_if.sv
// Note-spawn handshake: the producer offers a lane, the engine answers with ready.
interface note_lane_engine_if #(
   parameter int LANES = 4
);
   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

   logic          spawn_valid;
   logic [LW-1:0] spawn_lane;
   logic          spawn_ready;

   modport master (output spawn_valid, output spawn_lane, input  spawn_ready);
   modport slave  (input  spawn_valid, input  spawn_lane, output spawn_ready);
endinterface

// File: rtl/note_lane_engine_lane.sv
// One note lane: slot storage, spawn/move/hit/miss update and the per-pixel cover flag.
module note_lane
   import note_pkg::*;
#(
   parameter int LANE     = 0,
   parameter int SLOTS    = 8,
   parameter int LANE_W   = 160,
   parameter int SCREEN_H = 480,
   parameter int NOTE_H   = 20,
   parameter int MARGIN   = 16,
   parameter int SPEED    = 2,
   parameter int HIT_Y    = 400,
   parameter int HIT_WIN  = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_frame_tick,
   input  logic          i_hit_edge,
   input  logic          i_spawn_en,
   input  logic [CW-1:0] i_px,
   input  logic [CW-1:0] i_py,
   output logic          o_has_free,
   output logic          o_hit_pulse,
   output logic          o_miss_pulse,
   output logic          o_cover
);
   localparam int            IW   = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam logic [CW-1:0] X_LO = CW'(LANE * LANE_W + MARGIN);
   localparam logic [CW-1:0] X_HI = CW'((LANE + 1) * LANE_W - MARGIN - 1);

   slot_t         r_slot    [SLOTS];
   slot_t         w_slot_nx [SLOTS];
   logic          r_hit_pulse;
   logic          r_miss_pulse;
   logic          w_free_found;
   logic          w_hit_found;
   logic          w_miss_any;
   logic          w_row_hit;
   logic [IW-1:0] w_free_idx;
   logic [IW-1:0] w_hit_idx;

   // Window test written as two one-sided compares so nothing goes negative.
   function automatic logic in_window(input logic [YW-1:0] ytop);
      logic [CW-1:0] centre;
      centre = CW'(ytop) + CW'(NOTE_H / 2);
      return (centre + CW'(HIT_WIN) >= CW'(HIT_Y)) && (centre <= CW'(HIT_Y + HIT_WIN));
   endfunction

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      w_free_found = 1'b0;
      w_free_idx   = '0;
      w_hit_found  = 1'b0;
      w_hit_idx    = '0;
      for (int i = SLOTS - 1; i >= 0; i--) begin
         if (!r_slot[i].valid) begin
            w_free_found = 1'b1;
            w_free_idx   = IW'(i);
         end
         if (r_slot[i].valid && in_window(r_slot[i].ytop)) begin
            w_hit_found = 1'b1;
            w_hit_idx   = IW'(i);
         end
      end
   end

   // A hit clear beats the move; spawn uses the free slot seen before this cycle.
   always_comb begin
      w_miss_any = 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
         w_slot_nx[i] = r_slot[i];
         if (i_hit_edge && w_hit_found && (w_hit_idx == IW'(i))) begin
            w_slot_nx[i].valid = 1'b0;
         end else if (r_slot[i].valid && i_frame_tick) begin
            if (CW'(r_slot[i].ytop) + CW'(SPEED) >= CW'(SCREEN_H)) begin
               w_slot_nx[i].valid = 1'b0;
               w_miss_any         = 1'b1;
            end else begin
               w_slot_nx[i].ytop = r_slot[i].ytop + YW'(SPEED);
            end
         end
         if (i_spawn_en && w_free_found && (w_free_idx == IW'(i))) begin
            w_slot_nx[i] = '{valid: 1'b1, ytop: '0};
         end
      end
   end

   always_comb begin
      w_row_hit = 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
         if (r_slot[i].valid && (i_py >= CW'(r_slot[i].ytop)) &&
             (i_py <= CW'(r_slot[i].ytop) + CW'(NOTE_H - 1))) begin
            w_row_hit = 1'b1;
         end
      end
   end

   // NOTE: the slot array is reset (not left as plain memory) because its valid bits are the lane state;
   // clocked state uses <= only so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < SLOTS; i++) r_slot[i] <= '0;
         r_hit_pulse  <= 1'b0;
         r_miss_pulse <= 1'b0;
      end else begin
         for (int i = 0; i < SLOTS; i++) r_slot[i] <= w_slot_nx[i];
         r_hit_pulse  <= i_hit_edge & w_hit_found;
         r_miss_pulse <= w_miss_any;
      end
   end

   assign o_has_free   = w_free_found;
   assign o_hit_pulse  = r_hit_pulse;
   assign o_miss_pulse = r_miss_pulse;
   assign o_cover      = w_row_hit && (i_px >= X_LO) && (i_px <= X_HI);
endmodule

// File: rtl/note_lane_engine.sv
// Rhythm-game note engine: per-lane note slots, frame/button edge detection, pixel compositing, scoring.
module note_lane_engine
   import note_pkg::*;
#(
   parameter int LANES    = 4,
   parameter int SLOTS    = 8,
   parameter int SCREEN_W = 640,
   parameter int SCREEN_H = 480,
   parameter int NOTE_H   = 20,
   parameter int MARGIN   = 16,
   parameter int SPEED    = 2,
   parameter int HIT_Y    = 400,
   parameter int HIT_WIN  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              frame_end,
   input  logic [9:0]        x,
   input  logic [8:0]        y,
   input  logic              active,
   input  logic [11:0]       bg_color,
   note_lane_engine_if.slave spawn_if,
   input  logic [LANES-1:0]  hit_btn,
   output logic [11:0]       color_out,
   output logic [LANES-1:0]  hit_pulse,
   output logic [LANES-1:0]  miss_pulse,
   output logic [15:0]       hit_count,
   output logic [15:0]       miss_count
);
   localparam int LANE_W = SCREEN_W / LANES;

   logic             r_frame_d;
   logic             r_frame_tick;
   logic [LANES-1:0] r_btn_d;
   logic [LANES-1:0] r_hit_edge;
   logic [LANES-1:0] w_free;
   logic [LANES-1:0] w_cover;
   logic [LANES-1:0] w_spawn_en;
   logic             w_lane_free;
   logic [CW-1:0]    w_px;
   logic [CW-1:0]    w_py;
   logic [11:0]      w_color;

   assign w_px = CW'(x);
   assign w_py = CW'(y);

   // Out-of-range lane numbers simply report not-ready.
   always_comb begin
      w_lane_free = 1'b0;
      for (int l = 0; l < LANES; l++) begin
         if (int'(spawn_if.spawn_lane) == l) w_lane_free = w_free[l];
      end
   end

   assign spawn_if.spawn_ready = w_lane_free & ~r_frame_tick;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign w_spawn_en[g] = spawn_if.spawn_valid && spawn_if.spawn_ready &&
                             (int'(spawn_if.spawn_lane) == g);

      note_lane #(
         .LANE(g), .SLOTS(SLOTS), .LANE_W(LANE_W), .SCREEN_H(SCREEN_H), .NOTE_H(NOTE_H),
         .MARGIN(MARGIN), .SPEED(SPEED), .HIT_Y(HIT_Y), .HIT_WIN(HIT_WIN)
      ) u_lane (
         .clk          (clk),
         .reset        (reset),
         .i_frame_tick (r_frame_tick),
         .i_hit_edge   (r_hit_edge[g]),
         .i_spawn_en   (w_spawn_en[g]),
         .i_px         (w_px),
         .i_py         (w_py),
         .o_has_free   (w_free[g]),
         .o_hit_pulse  (hit_pulse[g]),
         .o_miss_pulse (miss_pulse[g]),
         .o_cover      (w_cover[g])
      );
   end

   always_comb begin
      w_color = bg_color;
      if ((w_py >= CW'(HIT_Y)) && (w_py <= CW'(HIT_Y + 1))) w_color = 12'hFFF;
      for (int l = LANES - 1; l >= 0; l--) begin
         if (w_cover[l]) w_color = lane_color(2'(l));
      end
      if (!active) w_color = 12'h000;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_frame_d    <= 1'b0;
         r_frame_tick <= 1'b0;
         r_btn_d      <= '0;
         r_hit_edge   <= '0;
         color_out    <= 12'h000;
         hit_count    <= 16'h0000;
         miss_count   <= 16'h0000;
      end else begin
         r_frame_d    <= frame_end;
         r_frame_tick <= frame_end & ~r_frame_d;
         r_btn_d      <= hit_btn;
         r_hit_edge   <= hit_btn & ~r_btn_d;
         color_out    <= w_color;
         hit_count    <= sat_add(hit_count, $countones(hit_pulse));
         miss_count   <= sat_add(miss_count, $countones(miss_pulse));
      end
   end
endmodule

// File: tb/tb_note_lane_engine.sv
// Scoreboard bench for note_lane_engine: stimulus queues expected events/pixels, a monitor pops and compares.
module tb_note_lane_engine;

   typedef struct {
      logic [11:0] color;
      int          px;
      int          py;
   } pix_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        frame_end = 1'b0;
   logic [9:0]  x = '0;
   logic [8:0]  y = '0;
   logic        active = 1'b0;
   logic [11:0] bg_color = 12'h5A5;
   logic [3:0]  hit_btn = '0;
   logic [11:0] color_out;
   logic [3:0]  hit_pulse;
   logic [3:0]  miss_pulse;
   logic [15:0] hit_count;
   logic [15:0] miss_count;

   int tests = 0;
   int fails = 0;

   logic [3:0] exp_hit_q  [$];
   logic [3:0] exp_miss_q [$];
   pix_t       exp_pix_q  [$];
   logic       probe = 1'b0;
   logic       probe_q = 1'b0;

   note_lane_engine_if #(.LANES(4)) spawn_if ();

   note_lane_engine dut (
      .clk        (clk),
      .reset      (reset),
      .frame_end  (frame_end),
      .x          (x),
      .y          (y),
      .active     (active),
      .bg_color   (bg_color),
      .spawn_if   (spawn_if),
      .hit_btn    (hit_btn),
      .color_out  (color_out),
      .hit_pulse  (hit_pulse),
      .miss_pulse (miss_pulse),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compares whenever the DUT presents an event or a probed pixel.
   always @(posedge clk) probe_q <= probe;

   always @(negedge clk) begin
      if (hit_pulse !== 4'b0000) begin
         if (exp_hit_q.size() == 0) check("hit_pulse (none expected)", 32'(hit_pulse), 32'h0);
         else                       check("hit_pulse", 32'(hit_pulse), 32'(exp_hit_q.pop_front()));
      end
      if (miss_pulse !== 4'b0000) begin
         if (exp_miss_q.size() == 0) check("miss_pulse (none expected)", 32'(miss_pulse), 32'h0);
         else                        check("miss_pulse", 32'(miss_pulse), 32'(exp_miss_q.pop_front()));
      end
      if (probe_q) begin
         if (exp_pix_q.size() == 0) begin
            check("pixel probe without expectation", 32'(color_out), 32'hFFFF_FFFF);
         end else begin
            pix_t p;
            p = exp_pix_q.pop_front();
            check($sformatf("color_out at (%0d,%0d)", p.px, p.py), 32'(color_out), 32'(p.color));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic frame(input logic [3:0] press);
      frame_end = 1'b1;
      hit_btn   = hit_btn | press;
      idle(1);
      frame_end = 1'b0;
      idle(2);
   endtask

   task automatic frames(input int n);
      repeat (n) frame(4'b0000);
   endtask

   task automatic press(input logic [3:0] lanes);
      hit_btn = lanes;
      idle(4);
      hit_btn = 4'b0000;
      idle(2);
   endtask

   task automatic spawn(input int lane, input logic exp_ready);
      spawn_if.spawn_valid = 1'b1;
      spawn_if.spawn_lane  = 2'(lane);
      #1;
      check($sformatf("spawn_ready lane %0d", lane), 32'(spawn_if.spawn_ready), 32'(exp_ready));
      idle(1);
      spawn_if.spawn_valid = 1'b0;
   endtask

   task automatic peek_ready(input int lane, input logic exp_ready);
      spawn_if.spawn_lane = 2'(lane);
      #1;
      check($sformatf("spawn_ready peek lane %0d", lane), 32'(spawn_if.spawn_ready), 32'(exp_ready));
   endtask

   task automatic pixel(input int px, input int py, input logic act, input logic [11:0] exp);
      pix_t p;
      x = 10'(px);
      y = 9'(py);
      active = act;
      p.color = exp;
      p.px = px;
      p.py = py;
      exp_pix_q.push_back(p);
      probe = 1'b1;
      idle(1);
      probe  = 1'b0;
      active = 1'b0;
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      spawn_if.spawn_valid = 1'b0;
      spawn_if.spawn_lane  = 2'd0;

      // Reset state, sampled mid-cycle while reset is held.
      #22;
      check("reset color_out", 32'(color_out), 32'h0);
      check("reset hit_pulse", 32'(hit_pulse), 32'h0);
      check("reset miss_pulse", 32'(miss_pulse), 32'h0);
      check("reset hit_count", 32'(hit_count), 32'h0);
      check("reset miss_count", 32'(miss_count), 32'h0);
      check("reset spawn_ready", 32'(spawn_if.spawn_ready), 32'h1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      idle(2);

      // Lane 0 reaches ytop=400 after 200 ticks; lane 2 trails by one tick (398).
      spawn(0, 1'b1);
      frame(4'b0000);
      spawn(2, 1'b1);
      frames(199);
      pixel(80, 405, 1'b1, 12'h0F0);
      pixel(80, 405, 1'b0, 12'h000);
      pixel(80, 399, 1'b1, 12'h5A5);
      pixel(80, 420, 1'b1, 12'h5A5);
      pixel(300, 400, 1'b1, 12'hFFF);
      pixel(400, 398, 1'b1, 12'hFF0);
      pixel(400, 417, 1'b1, 12'hFF0);
      pixel(400, 418, 1'b1, 12'h5A5);
      pixel(336, 410, 1'b1, 12'hFF0);
      pixel(335, 410, 1'b1, 12'h5A5);
      pixel(463, 410, 1'b1, 12'hFF0);
      pixel(464, 410, 1'b1, 12'h5A5);

      // Misses: lane 0 on its tick 240, lane 2 one tick later.
      frames(39);
      exp_miss_q.push_back(4'b0001);
      frame(4'b0000);
      exp_miss_q.push_back(4'b0100);
      frame(4'b0000);
      idle(1);
      check("miss_count after two misses", 32'(miss_count), 32'd2);
      check("hit_count still zero", 32'(hit_count), 32'd0);

      // Lane 1: press just outside the window (ytop 372), then at ytop 390.
      spawn(1, 1'b1);
      frames(186);
      press(4'b0010);
      frames(9);
      exp_hit_q.push_back(4'b0010);
      press(4'b0010);
      check("hit_count after lane 1 hit", 32'(hit_count), 32'd1);
      pixel(240, 395, 1'b1, 12'h5A5);
      press(4'b0001);

      // Fill lane 3; ninth spawn refused, lane 0 still ready.
      for (int i = 0; i < 8; i++) spawn(3, 1'b1);
      spawn(3, 1'b0);
      peek_ready(3, 1'b0);
      peek_ready(0, 1'b1);
      pixel(560, 5, 1'b1, 12'h00F);
      pixel(560, 20, 1'b1, 12'h5A5);

      // Hit on the tick cycle with lane 0 at ytop 406 (window edge, pre-move).
      spawn(0, 1'b1);
      frames(203);
      exp_hit_q.push_back(4'b0001);
      frame(4'b0001);
      hit_btn = 4'b0000;
      idle(2);
      check("hit_count after edge hit", 32'(hit_count), 32'd2);
      pixel(80, 410, 1'b1, 12'h5A5);
      frames(35);
      exp_miss_q.push_back(4'b1000);
      frame(4'b0000);
      idle(1);
      check("miss_count after lane 3 batch", 32'(miss_count), 32'd3);

      // Mid-cycle reset with notes live.
      spawn(1, 1'b1);
      spawn(2, 1'b1);
      frames(10);
      pixel(240, 25, 1'b1, 12'hF00);
      @(negedge clk);
      #2;
      reset = 1'b0;
      #1;
      check("mid-reset color_out", 32'(color_out), 32'h0);
      check("mid-reset hit_count", 32'(hit_count), 32'h0);
      check("mid-reset miss_count", 32'(miss_count), 32'h0);
      check("mid-reset miss_pulse", 32'(miss_pulse), 32'h0);
      peek_ready(1, 1'b1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      idle(1);
      frame(4'b0000);
      pixel(240, 27, 1'b1, 12'h5A5);
      pixel(400, 27, 1'b1, 12'h5A5);
      idle(2);
      check("post-reset miss_count", 32'(miss_count), 32'h0);

      check("hit queue drained", 32'(exp_hit_q.size()), 32'd0);
      check("miss queue drained", 32'(exp_miss_q.size()), 32'd0);
      check("pixel queue drained", 32'(exp_pix_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
